fetch_queue: RTL and testbench

- Decoupled instruction-fetch front end for the pipelined core. It replaces the single-cycle fetch path with a parametrised prefetch queue.
- Issues sequential PC requests on the instruction bus using the addr_ok/data_ok split handshake, and tolerates multi-cycle bus latency.
- Buffers up to DEPTH fetched instructions for decode and squashes stale fetches on a branch/jump redirect from execute.

---
 rtl/fetch_queue.sv | 233 +++++++++++++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch prefetch queue on an addr_ok/data_ok split bus, with redirect squash.
// Optional same-cycle head bypass of an empty queue when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       ireq_valid,
  output logic [XLEN-1:0]            ireq_addr,
  input  logic                       iresp_addr_ok,
  input  logic                       iresp_data_ok,
  input  logic [INSTR_W-1:0]         iresp_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [INSTR_W-1:0]         deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT      = 3'd2,
    S_KILL_REQ  = 3'd3,
    S_KILL_WAIT = 3'd4
  } state_e;

  state_e              state_r;
  logic                ireq_valid_r;
  logic [XLEN-1:0]     req_pc_r;
  logic [XLEN-1:0]     fetch_pc_r;
  logic [XLEN-1:0]     fetch_pc_nxt_s;
  logic [XLEN-1:0]     mem_pc_r    [DEPTH];
  logic [INSTR_W-1:0]  mem_instr_r [DEPTH];
  logic [PW-1:0]       head_r;
  logic [PW-1:0]       tail_r;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;
  logic                resp_live_s;
  logic                bypass_s;
  logic                push_s;
  logic                pop_s;
  logic                space_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PTR_ONE;
    end
    return n;
  endfunction

  // Response acceptance, queue occupancy bookkeeping and next fetch PC
  always_comb begin
    resp_live_s    = 1'b0;
    bypass_s       = 1'b0;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    count_nxt_s    = count_r;
    space_s        = 1'b0;
    fetch_pc_nxt_s = fetch_pc_r;

    // A response is only kept if it belongs to a live request and no redirect squashes it now.
    if (redirect_valid) begin
      resp_live_s = 1'b0;
    end else if (state_r == S_REQ) begin
      resp_live_s = iresp_addr_ok && iresp_data_ok;
    end else if (state_r == S_WAIT) begin
      resp_live_s = iresp_data_ok;
    end else begin
      resp_live_s = 1'b0;
    end

`ifdef FETCHQ_BYPASS_EN
    bypass_s = resp_live_s && (count_r == CNT_ZERO);
`else
    bypass_s = 1'b0;
`endif

    pop_s  = (count_r != CNT_ZERO) && deq_ready;
    push_s = resp_live_s && !(bypass_s && deq_ready);

    if (redirect_valid) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      count_nxt_s = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
    space_s = (count_nxt_s < DEPTH_C);

    if (redirect_valid) begin
      fetch_pc_nxt_s = redirect_pc;
    end else if ((state_r == S_REQ) && iresp_addr_ok) begin
      fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
  end

  // Fetch FSM: request issue, response wait and stale-transaction draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      ireq_valid_r <= 1'b0;
      req_pc_r     <= RESET_PC;
      fetch_pc_r   <= RESET_PC;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (space_s) begin
            state_r      <= S_REQ;
            ireq_valid_r <= 1'b1;
            req_pc_r     <= fetch_pc_nxt_s;
          end
        end
        S_REQ: begin
          // A same-cycle response under redirect is simply dropped; space_s is then true.
          if (iresp_addr_ok) begin
            if (iresp_data_ok && space_s) begin
              state_r      <= S_REQ;
              ireq_valid_r <= 1'b1;
              req_pc_r     <= fetch_pc_nxt_s;
            end else if (iresp_data_ok) begin
              state_r      <= S_IDLE;
              ireq_valid_r <= 1'b0;
            end else if (redirect_valid) begin
              state_r      <= S_KILL_WAIT;
              ireq_valid_r <= 1'b0;
            end else begin
              state_r      <= S_WAIT;
              ireq_valid_r <= 1'b0;
            end
          end else if (redirect_valid) begin
            state_r <= S_KILL_REQ;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok && space_s) begin
            state_r      <= S_REQ;
            ireq_valid_r <= 1'b1;
            req_pc_r     <= fetch_pc_nxt_s;
          end else if (iresp_data_ok) begin
            state_r <= S_IDLE;
          end else if (redirect_valid) begin
            state_r <= S_KILL_WAIT;
          end
        end
        S_KILL_REQ: begin
          if (iresp_addr_ok) begin
            ireq_valid_r <= 1'b0;
            state_r      <= iresp_data_ok ? S_IDLE : S_KILL_WAIT;
          end
        end
        S_KILL_WAIT: begin
          if (iresp_data_ok) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          ireq_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (redirect_valid) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= ptr_next(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_next(head_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage, written at the tail on an accepted response
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc_r[tail_r]    <= req_pc_r;
      mem_instr_r[tail_r] <= iresp_data;
    end
  end

  // Head presentation to decode, optionally bypassing an empty queue
  always_comb begin
    deq_valid = 1'b0;
    deq_pc    = mem_pc_r[head_r];
    deq_instr = mem_instr_r[head_r];
    if (bypass_s) begin
      deq_valid = 1'b1;
      deq_pc    = req_pc_r;
      deq_instr = iresp_data;
    end else begin
      deq_valid = (count_r != CNT_ZERO);
      deq_pc    = mem_pc_r[head_r];
      deq_instr = mem_instr_r[head_r];
    end
  end

  assign ireq_valid = ireq_valid_r;
  assign ireq_addr  = req_pc_r;
  assign count      = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: sequential fetch, fill/drain, redirect squash, async reset, bypass.
module tb_fetch_queue;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [63:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(
    .XLEN(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a, input logic d, input logic [31:0] data);
    iresp_addr_ok = a;
    iresp_data_ok = d;
    iresp_data    = data;
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    deq_ready = 1'b0;
    bus(1'b0, 1'b0, 32'h0);
    #3;
    check("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    check("rst_deq_valid", {63'h0, deq_valid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);

    // Sequential fetch: addr_ok immediate, data_ok one cycle later, decode always ready
    step(); reset = 1'b1;
    deq_ready = 1'b1;
    bus(1'b1, 1'b0, 32'h0);
    step();
    check("seq_req0_valid", {63'h0, ireq_valid}, 64'h1);
    check("seq_req0_addr", ireq_addr, RST_PC);
    step();
    check("seq_wait0_valid", {63'h0, ireq_valid}, 64'h0);
    bus(1'b0, 1'b1, 32'h1111_0001);
    step();
    check("seq_e0_count", {61'h0, count}, 64'h1);
    check("seq_e0_pc", deq_pc, RST_PC);
    check("seq_e0_instr", {32'h0, deq_instr}, 64'h1111_0001);
    check("seq_req1_addr", ireq_addr, RST_PC + 64'h4);
    bus(1'b1, 1'b0, 32'h0);
    step();
    check("seq_pop_count", {61'h0, count}, 64'h0);
    bus(1'b0, 1'b1, 32'h1111_0002);
    step();
    check("seq_e1_count", {61'h0, count}, 64'h1);
    check("seq_e1_pc", deq_pc, RST_PC + 64'h4);
    check("seq_e1_instr", {32'h0, deq_instr}, 64'h1111_0002);
    check("seq_req2_addr", ireq_addr, RST_PC + 64'h8);

    // Fill to DEPTH with decode stalled and a zero-wait bus
    #2; reset = 1'b0; deq_ready = 1'b0; bus(1'b0, 1'b0, 32'h0);
    step(); reset = 1'b1;
    bus(1'b1, 1'b1, 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      check("fill_req_valid", {63'h0, ireq_valid}, 64'h1);
      check("fill_req_addr", ireq_addr, RST_PC + 64'(4 * k));
      iresp_data = 32'hA000_0000 + 32'(k);
      step();
    end
    check("full_count", {61'h0, count}, 64'h4);
    check("full_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    step(); step();
    check("full_hold_valid", {63'h0, ireq_valid}, 64'h0);
    check("full_hold_count", {61'h0, count}, 64'h4);

    // Drain four entries with the bus idle
    deq_ready = 1'b1;
    bus(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", {63'h0, deq_valid}, 64'h1);
      check("drain_pc", deq_pc, RST_PC + 64'(4 * k));
      check("drain_instr", {32'h0, deq_instr}, 64'hA000_0000 + 64'(k));
      step();
    end
    check("drain_count", {61'h0, count}, 64'h0);
    check("drain_deq_valid", {63'h0, deq_valid}, 64'h0);
    check("resume_valid", {63'h0, ireq_valid}, 64'h1);
    check("resume_addr", ireq_addr, RST_PC + 64'h10);

    // Redirect while waiting for data; stale response arrives later
    deq_ready = 1'b0;
    bus(1'b1, 1'b1, 32'hB000_0000);
    step();
    check("rdw_pre_count", {61'h0, count}, 64'h1);
    bus(1'b1, 1'b0, 32'h0);
    step();
    check("rdw_in_wait", {63'h0, ireq_valid}, 64'h0);
    bus(1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("rdw_flush_count", {61'h0, count}, 64'h0);
    check("rdw_flush_deq", {63'h0, deq_valid}, 64'h0);
    step();
    check("rdw_kill_ireq", {63'h0, ireq_valid}, 64'h0);
    step();
    bus(1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    check("rdw_stale_deq", {63'h0, deq_valid}, 64'h0);
    check("rdw_stale_count", {61'h0, count}, 64'h0);
    bus(1'b0, 1'b0, 32'h0);
    step();
    check("rdw_next_valid", {63'h0, ireq_valid}, 64'h1);
    check("rdw_next_addr", ireq_addr, 64'h8000_0100);

    // Redirect during an unaccepted request
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("rdr_hold_valid0", {63'h0, ireq_valid}, 64'h1);
    check("rdr_hold_addr0", ireq_addr, 64'h8000_0100);
    step();
    check("rdr_hold_valid1", {63'h0, ireq_valid}, 64'h1);
    check("rdr_hold_addr1", ireq_addr, 64'h8000_0100);
    bus(1'b1, 1'b0, 32'h0);
    step();
    check("rdr_accept_valid", {63'h0, ireq_valid}, 64'h0);
    bus(1'b0, 1'b1, 32'hDEAD_0001);
    step();
    check("rdr_stale_deq", {63'h0, deq_valid}, 64'h0);
    bus(1'b0, 1'b0, 32'h0);
    step();
    check("rdr_next_valid", {63'h0, ireq_valid}, 64'h1);
    check("rdr_next_addr", ireq_addr, 64'h8000_0200);

    // Asynchronous reset mid-WAIT with two queued entries
    bus(1'b1, 1'b1, 32'hC000_0000);
    step();
    iresp_data = 32'hC000_0001;
    step();
    bus(1'b1, 1'b0, 32'h0);
    step();
    check("ar_pre_count", {61'h0, count}, 64'h2);
    check("ar_pre_pc", deq_pc, 64'h8000_0200);
    bus(1'b0, 1'b0, 32'h0);
    #2; reset = 1'b0; #1;
    check("ar_deq_valid", {63'h0, deq_valid}, 64'h0);
    check("ar_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    check("ar_count", {61'h0, count}, 64'h0);
    step(); reset = 1'b1;
    step();
    check("ar_restart_addr", ireq_addr, RST_PC);

    // Response into an empty queue: bypass timing versus one-cycle storage latency
    deq_ready = 1'b1;
    bus(1'b1, 1'b0, 32'h0);
    step();
    bus(1'b0, 1'b1, 32'h0000_0013);
    #1;
`ifdef FETCHQ_BYPASS_EN
    check("byp_same_valid", {63'h0, deq_valid}, 64'h1);
    check("byp_same_instr", {32'h0, deq_instr}, 64'h13);
    check("byp_same_pc", deq_pc, RST_PC);
    step();
    check("byp_consumed_count", {61'h0, count}, 64'h0);
`else
    check("nobyp_same_valid", {63'h0, deq_valid}, 64'h0);
    step();
    check("nobyp_next_valid", {63'h0, deq_valid}, 64'h1);
    check("nobyp_next_instr", {32'h0, deq_instr}, 64'h13);
    check("nobyp_next_pc", deq_pc, RST_PC);
`endif
    bus(1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
